ddr_cmd_sequencer: RTL
======================

# ddr_cmd_sequencer

Command-issuing end of the scheduler/controller interface in the DDR memory subsystem. Accepts row-open/transfer/close requests from the scheduler (`cmd_*`) and turns them into timed DDR SDRAM commands: ACTIVE, READ, WRITE, PRECHARGE ALL and AUTO REFRESH. Returns the `ctl_*` progress strobes the scheduler advances on. Owns the refresh interval and runs the `rfc_req`/`rfc_ack`/`rfc_end` handshake. Sits between the scheduler and the DDR IOB/datapath.

## Interface
- `TRCD`, 2: cycles from ACTIVE to first READ/WRITE; must be ≥2.
- `TRP`, 2: cycles from PRECHARGE to next ACTIVE/REFRESH.
- `TWR`, 2: cycles from last WRITE to PRECHARGE.
- `TRFC`, 8: cycles from AUTO REFRESH to next command.
- `TREFI`, 780: refresh interval in cycles.
- `clock_i`  in  1: the single clock.
- `reset_i`  in  1: reset, synchronous, active-high.
- `enable_i`  in  1: controller init done. While low, the block behaves as in reset.
- `cmd_start_i`  in  1: scheduler requests ACTIVE of `cmd_bank_i`/`cmd_row_i`.
- `cmd_read_i`  in  1: 1 = read, 0 = write, for the open row.
- `cmd_last_i`  in  1: close the row (PRECHARGE ALL).
- `cmd_bank_i`  in  2: bank address.
- `cmd_row_i`  in  13: row address.
- `cmd_col_i`  in  8: column pair address. The pin column is `{cmd_col_i,1'b0}`.
- `ctl_active_o`  out  1: ACTIVE being issued this cycle.
- `ctl_read_o`  out  1: READ being issued this cycle.
- `ctl_write_o`  out  1: WRITE being issued this cycle.
- `rfc_req_o`  out  1: refresh due.
- `rfc_ack_i`  in  1: scheduler permits refresh (one-cycle pulse).
- `rfc_end_o`  out  1: high when no refresh is in progress.
- `ddr_cmd_o`  out  3: `{ras_n,cas_n,we_n}`.
- `ddr_ba_o`  out  2: bank address pins.
- `ddr_a_o`  out  13: address pins.

## Operation
- Command codes: NOP 111, ACTIVE 011, READ 101, WRITE 100, PRECHARGE 010, REFRESH 001. PRECHARGE drives A10=1 (all banks).
- States:
  - IDLE: accepts refresh or `cmd_start_i`. Refresh-pending wins.
  - RCD: counts TRCD−1 NOPs after ACTIVE, then goes to XFER.
  - XFER, while `cmd_last_i`=0: issues READ if `cmd_read_i`, else WRITE, every cycle at `cmd_col_i`. Bank/row are those latched at ACTIVE.
  - XFER, when `cmd_last_i`=1: issues PRECHARGE and goes to PRE. If a WRITE was issued in the last TWR cycles, PRECHARGE is held (NOPs) until TWR has elapsed.
  - PRE: TRP−1 NOPs, then IDLE.
  - RFC: REFRESH issued, TRFC−1 NOPs, then IDLE.
- `ctl_active_o` = IDLE & `cmd_start_i` & no refresh pending.
- `ctl_read_o` / `ctl_write_o` = XFER & `cmd_last_i`=0 & the respective direction.
- All three strobes are combinational (Mealy): high in the cycle whose closing edge registers the command onto `ddr_cmd_o`. The scheduler therefore advances `cmd_col_i`/`cmd_last_i` on the same edge.
- Refresh:
  - Interval counter counts 0..TREFI−1 while enabled. At wrap it sets `rfc_req_o`, which holds until `rfc_ack_i`.
  - At most one refresh is outstanding. A further wrap while one is outstanding is absorbed.
  - On `rfc_ack_i`: `rfc_req_o` and `rfc_end_o` both fall at that clock edge, and refresh becomes pending.
  - Pending refresh issues REFRESH from IDLE. If PRE has not finished, REFRESH is issued on the first IDLE cycle.
  - `rfc_end_o` rises on exit from RFC.
- `cmd_start_i` is ignored outside IDLE. `cmd_last_i` is ignored outside XFER.

## Timing
- Reset / `enable_i` low values: state IDLE, `ddr_cmd_o`=NOP, `ddr_ba_o`=0, `ddr_a_o`=0, `rfc_req_o`=0, `rfc_end_o`=1, all `ctl_*`=0, all counters 0.
- Reset mid-operation aborts at once, with no PRECHARGE issued. Re-init is the init sequencer's job.
- `cmd_start_i` high in IDLE → ACTIVE on pins the next cycle. The first READ/WRITE is on pins TRCD cycles after ACTIVE.
- Single word: ACTIVE at t, READ at t+TRCD, PRECHARGE at t+TRCD+1, IDLE at t+TRCD+TRP+1.
- `rfc_ack_i` arriving while the block is in IDLE: REFRESH on pins the next cycle.
- `rfc_ack_i` and `cmd_start_i` in the same cycle: refresh wins, and `ctl_active_o` stays low.

## Structure
- Shared `ddr_defs` package holds the command codes, state encoding, and address widths (2/13/8). The scheduler uses the same package.
- One sub-module, `ddr_wait_timer`: loadable down-counter with a `done` flag, reused for TRCD/TRP/TWR/TRFC. The TREFI counter stays inline.

## Test plan
- Word read: bank 2, row 0x0ABC, col 0x10 → ACTIVE (ba=2, a=0x0ABC), 1 NOP, READ a=0x020, PRECHARGE with a[10]=1. `ctl_read_o` high exactly 1 cycle.
- Block read col 0xFC..0xFF, then `cmd_last_i` → 4 consecutive READs a=0x1F8..0x1FE, then PRECHARGE. No extra READ.
- Word write, TWR=3 → WRITE, 2 NOPs, PRECHARGE. `ctl_write_o` 1 cycle.
- TREFI=20, idle → `rfc_req_o` at cycle 20. Ack at 25 → req and end low at 26, REFRESH at 26, `rfc_end_o` high at 26+TRFC.
- `rfc_ack_i` with `cmd_start_i` in the same cycle → REFRESH first, ACTIVE only after `rfc_end_o` rises.
- `reset_i` asserted during XFER → next cycle NOP, IDLE, `rfc_end_o`=1, TREFI counter restarted.

Source files
------------

// File: rtl/ddr_defs_pkg.sv
// Shared DDR command-path definitions: pin command codes, sequencer states,
// address widths and the column-to-pin address mapping.
package ddr_defs;

  localparam int BA_W    = 2;
  localparam int ROW_W   = 13;
  localparam int COL_W   = 8;
  localparam int TIMER_W = 8;
  localparam int A10     = 10;

  // {ras_n, cas_n, we_n}
  typedef enum logic [2:0] {
    CMD_REFRESH   = 3'b001,
    CMD_PRECHARGE = 3'b010,
    CMD_ACTIVE    = 3'b011,
    CMD_WRITE     = 3'b100,
    CMD_READ      = 3'b101,
    CMD_NOP       = 3'b111
  } ddr_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RCD,
    ST_XFER,
    ST_PRE,
    ST_RFC
  } seq_state_e;

  // Column pairs: the pin column is the pair index with a zero LSB.
  function automatic logic [ROW_W-1:0] col_to_addr(input logic [COL_W-1:0] col);
    return ROW_W'({col, 1'b0});
  endfunction

endpackage

// File: rtl/ddr_wait_timer.sv
// Loadable down-counter; done is high whenever the count has reached zero.
module ddr_wait_timer
  import ddr_defs::*;
#(
  parameter int W = TIMER_W
) (
  input  logic         clock_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Load wins; otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Turns scheduler row/transfer/close requests into timed DDR commands and
// owns the refresh interval plus the rfc_req/rfc_ack/rfc_end handshake.
//
// state | meaning
// IDLE  | no row open; refresh or ACTIVE may be issued
// RCD   | NOPs after ACTIVE until the row is usable
// XFER  | READ/WRITE every cycle; PRECHARGE ALL once write recovery is met
// PRE   | NOPs after PRECHARGE
// RFC   | NOPs after AUTO REFRESH
module ddr_cmd_sequencer
  import ddr_defs::*;
#(
  parameter int TRCD  = 2,
  parameter int TRP   = 2,
  parameter int TWR   = 2,
  parameter int TRFC  = 8,
  parameter int TREFI = 780
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             cmd_start_i,
  input  logic             cmd_read_i,
  input  logic             cmd_last_i,
  input  logic [BA_W-1:0]  cmd_bank_i,
  input  logic [ROW_W-1:0] cmd_row_i,
  input  logic [COL_W-1:0] cmd_col_i,
  output logic             ctl_active_o,
  output logic             ctl_read_o,
  output logic             ctl_write_o,
  output logic             rfc_req_o,
  input  logic             rfc_ack_i,
  output logic             rfc_end_o,
  output logic [2:0]       ddr_cmd_o,
  output logic [BA_W-1:0]  ddr_ba_o,
  output logic [ROW_W-1:0] ddr_a_o
);

  localparam int REFI_W = (TREFI > 1) ? $clog2(TREFI) : 1;
  localparam logic [REFI_W-1:0]  REFI_LAST = REFI_W'(TREFI - 1);
  // Load values count the wait cycles that follow the cycle the command is on pins.
  localparam logic [TIMER_W-1:0] LD_RCD = TIMER_W'(TRCD - 2);
  localparam logic [TIMER_W-1:0] LD_RP  = TIMER_W'(TRP - 1);
  localparam logic [TIMER_W-1:0] LD_WR  = TIMER_W'(TWR - 1);
  localparam logic [TIMER_W-1:0] LD_RFC = TIMER_W'(TRFC - 1);
  localparam logic [ROW_W-1:0]   A_ALL  = ROW_W'(1) << A10;

  seq_state_e         state_q, state_d;
  ddr_cmd_e           cmd_q, cmd_d;
  logic [BA_W-1:0]    ba_q, ba_d, bank_q, bank_d;
  logic [ROW_W-1:0]   a_q, a_d, row_q, row_d;
  logic [REFI_W-1:0]  refi_q, refi_d;
  logic               rfc_req_q, rfc_req_d;
  logic               rfc_end_q, rfc_end_d;
  logic               rfc_pend_q, rfc_pend_d;
  logic               srst, refi_wrap, ack_take, refresh_due;
  logic               tmr_load, tmr_done;
  logic [TIMER_W-1:0] tmr_val;

  // Disable is treated exactly like reset.
  assign srst        = reset_i | ~enable_i;
  assign refi_wrap   = (refi_q == REFI_LAST);
  assign ack_take    = rfc_ack_i & rfc_req_q;
  assign refresh_due = rfc_pend_q | ack_take;

  ddr_wait_timer #(.W(TIMER_W)) u_wait_timer (
    .clock_i    (clock_i),
    .reset_i    (srst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Refresh interval; a wrap is absorbed while a refresh is requested or in progress.
  always_comb begin
    refi_d    = refi_wrap ? '0 : refi_q + REFI_W'(1);
    rfc_req_d = (rfc_req_q & ~rfc_ack_i) | (refi_wrap & rfc_end_q & ~rfc_req_q);
  end

  // Next state, next pin image and the Mealy strobes.
  always_comb begin
    state_d      = state_q;
    cmd_d        = CMD_NOP;
    ba_d         = '0;
    a_d          = '0;
    bank_d       = bank_q;
    row_d        = row_q;
    tmr_load     = 1'b0;
    tmr_val      = '0;
    ctl_active_o = 1'b0;
    ctl_read_o   = 1'b0;
    ctl_write_o  = 1'b0;
    rfc_pend_d   = rfc_pend_q | ack_take;
    rfc_end_d    = rfc_end_q & ~ack_take;
    unique case (state_q)
      ST_IDLE: begin
        if (refresh_due) begin
          cmd_d      = CMD_REFRESH;
          rfc_pend_d = 1'b0;
          tmr_load   = 1'b1;
          tmr_val    = LD_RFC;
          state_d    = ST_RFC;
        end else if (cmd_start_i) begin
          ctl_active_o = 1'b1;
          cmd_d        = CMD_ACTIVE;
          ba_d         = cmd_bank_i;
          a_d          = cmd_row_i;
          bank_d       = cmd_bank_i;
          row_d        = cmd_row_i;
          tmr_load     = 1'b1;
          tmr_val      = LD_RCD;
          state_d      = ST_RCD;
        end
      end
      ST_RCD: begin
        if (tmr_done) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (!cmd_last_i) begin
          ba_d = bank_q;
          a_d  = col_to_addr(cmd_col_i);
          if (cmd_read_i) begin
            ctl_read_o = 1'b1;
            cmd_d      = CMD_READ;
          end else begin
            ctl_write_o = 1'b1;
            cmd_d       = CMD_WRITE;
            tmr_load    = 1'b1;
            tmr_val     = LD_WR;
          end
        end else if (tmr_done) begin
          cmd_d    = CMD_PRECHARGE;
          a_d      = A_ALL;
          tmr_load = 1'b1;
          tmr_val  = LD_RP;
          state_d  = ST_PRE;
        end
      end
      ST_PRE: begin
        if (tmr_done) state_d = ST_IDLE;
      end
      ST_RFC: begin
        if (tmr_done) begin
          rfc_end_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (srst) begin
      ctl_active_o = 1'b0;
      ctl_read_o   = 1'b0;
      ctl_write_o  = 1'b0;
    end
  end

  // State, pin and refresh registers; abort drops straight to the idle image.
  always_ff @(posedge clock_i) begin
    if (srst) begin
      state_q    <= ST_IDLE;
      cmd_q      <= CMD_NOP;
      ba_q       <= '0;
      a_q        <= '0;
      bank_q     <= '0;
      row_q      <= '0;
      refi_q     <= '0;
      rfc_req_q  <= 1'b0;
      rfc_end_q  <= 1'b1;
      rfc_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      a_q        <= a_d;
      bank_q     <= bank_d;
      row_q      <= row_d;
      refi_q     <= refi_d;
      rfc_req_q  <= rfc_req_d;
      rfc_end_q  <= rfc_end_d;
      rfc_pend_q <= rfc_pend_d;
    end
  end

  assign ddr_cmd_o = cmd_q;
  assign ddr_ba_o  = ba_q;
  assign ddr_a_o   = a_q;
  assign rfc_req_o = rfc_req_q;
  assign rfc_end_o = rfc_end_q;

endmodule
